// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: walks the channels selected in chanMask from lowest
// to highest, requests one conversion per channel from the ADC reader and
// reports each result with a clamped millivolt code. Supports single scans
// on a start pulse and continuous scanning separated by SCAN_GAP idle cycles.
module adc_scan_sequencer #(
  parameter logic [31:0] SCAN_GAP = 32'd1000000,
  parameter logic [31:0] TIMEOUT  = 32'd2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  chanMask,
  input  logic        start,
  input  logic        continuous,
  output logic [1:0]  adcChannel,
  output logic        adcEnable,
  input  logic [15:0] adcOutputData,
  input  logic        adcDataReady,
  output logic        resultValid,
  output logic [1:0]  resultChannel,
  output logic [15:0] resultRaw,
  output logic [11:0] resultVoltage,
  output logic        busy,
  output logic        timeoutErr,
  output logic [7:0]  scanCount
);

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_START,
    WAIT_READY,
    STORE,
    GAP
  } state_t;

  state_t      state;
  logic [3:0]  scanMask;
  logic [1:0]  curChan;
  logic [15:0] capRaw;
  logic [31:0] toCnt;
  logic [31:0] gapCnt;

  logic        hasNext;
  logic [1:0]  nextChan;
  logic [1:0]  firstChan;
  logic        firstFound;
  logic        toExpire;
  logic        gapExpire;
  state_t      advState;

  assign busy = (state != IDLE);

  // Channel selection: lowest set bit of the live mask for a new scan, and
  // the next higher set bit of the latched mask for continuing a scan.
  always_comb begin
    hasNext    = 1'b0;
    nextChan   = curChan;
    firstChan  = '0;
    firstFound = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hasNext && (i > 32'(curChan)) && scanMask[i]) begin
        hasNext  = 1'b1;
        nextChan = 2'(i);
      end
      if (!firstFound && chanMask[i]) begin
        firstFound = 1'b1;
        firstChan  = 2'(i);
      end
    end
  end

  // Where the FSM goes once a channel is finished (stored or timed out).
  always_comb begin
    advState = IDLE;
    if (hasNext)
      advState = TRIGGER;
    else if (continuous)
      advState = GAP;
    toExpire  = ((toCnt + 32'd1) >= TIMEOUT);
    gapExpire = ((gapCnt + 32'd1) >= SCAN_GAP);
  end

  // Main sequencer FSM with registered ADC handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      scanMask      <= '0;
      curChan       <= '0;
      capRaw        <= '0;
      toCnt         <= '0;
      gapCnt        <= '0;
      adcChannel    <= '0;
      adcEnable     <= 1'b0;
      resultValid   <= 1'b0;
      resultChannel <= '0;
      resultRaw     <= '0;
      resultVoltage <= '0;
      timeoutErr    <= 1'b0;
      scanCount     <= '0;
    end else begin
      resultValid <= 1'b0;
      case (state)
        IDLE: begin
          if ((start || continuous) && (chanMask != '0)) begin
            scanMask <= chanMask;
            curChan  <= firstChan;
            state    <= TRIGGER;
          end
        end

        TRIGGER: begin
          adcChannel <= curChan;
          adcEnable  <= 1'b1;
          toCnt      <= '0;
          state      <= WAIT_START;
        end

        WAIT_START: begin
          if (toExpire) begin
            // Timeout skips STORE entirely and advances as a finished channel.
            adcEnable  <= 1'b0;
            timeoutErr <= 1'b1;
            toCnt      <= '0;
            gapCnt     <= '0;
            curChan    <= nextChan;
            state      <= advState;
            if (!hasNext)
              scanCount <= scanCount + 8'd1;
          end else begin
            toCnt <= toCnt + 32'd1;
            if (!adcDataReady)
              state <= WAIT_READY;
          end
        end

        WAIT_READY: begin
          if (toExpire) begin
            adcEnable  <= 1'b0;
            timeoutErr <= 1'b1;
            toCnt      <= '0;
            gapCnt     <= '0;
            curChan    <= nextChan;
            state      <= advState;
            if (!hasNext)
              scanCount <= scanCount + 8'd1;
          end else begin
            toCnt <= toCnt + 32'd1;
            if (adcDataReady) begin
              capRaw    <= adcOutputData;
              adcEnable <= 1'b0;
              state     <= STORE;
            end
          end
        end

        STORE: begin
          resultValid   <= 1'b1;
          resultChannel <= curChan;
          resultRaw     <= capRaw;
          resultVoltage <= capRaw[15] ? 12'd0 : capRaw[14:3];
          gapCnt        <= '0;
          curChan       <= nextChan;
          state         <= advState;
          if (!hasNext)
            scanCount <= scanCount + 8'd1;
        end

        GAP: begin
          if (gapExpire) begin
            gapCnt <= '0;
            if (continuous && (chanMask != '0)) begin
              scanMask <= chanMask;
              curChan  <= firstChan;
              state    <= TRIGGER;
            end else begin
              state <= IDLE;
            end
          end else begin
            gapCnt <= gapCnt + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC reader model.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  chanMask;
  logic        start;
  logic        continuous;
  logic [1:0]  adcChannel;
  logic        adcEnable;
  logic [15:0] adcOutputData = '0;
  logic        adcDataReady = 1'b1;
  logic        resultValid;
  logic [1:0]  resultChannel;
  logic [15:0] resultRaw;
  logic [11:0] resultVoltage;
  logic        busy;
  logic        timeoutErr;
  logic [7:0]  scanCount;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  adc_scan_sequencer #(.SCAN_GAP(32'd10), .TIMEOUT(32'd50)) dut (
    .clk(clk), .reset(reset), .chanMask(chanMask), .start(start),
    .continuous(continuous), .adcChannel(adcChannel), .adcEnable(adcEnable),
    .adcOutputData(adcOutputData), .adcDataReady(adcDataReady),
    .resultValid(resultValid), .resultChannel(resultChannel),
    .resultRaw(resultRaw), .resultVoltage(resultVoltage), .busy(busy),
    .timeoutErr(timeoutErr), .scanCount(scanCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC reader model: ready drops one half-cycle after enable, result after 3 more.
  logic [15:0] rawTab [4];
  bit          stuck [4];
  bit          conv = 0;
  bit          done = 0;
  int          cnt = 0;
  int          readyCyc = 0;
  logic [1:0]  chLatched = '0;

  always @(negedge clk) begin
    if (conv) begin
      cnt--;
      if (cnt == 0) begin
        adcOutputData = rawTab[chLatched];
        adcDataReady = 1'b1;
        conv = 0;
        done = 1;
        readyCyc = cyc;
      end
    end else if (!adcEnable) begin
      done = 0;
    end else if (!done && adcDataReady && !stuck[adcChannel]) begin
      adcDataReady = 1'b0;
      conv = 1;
      cnt = 3;
      chLatched = adcChannel;
    end
  end

  // Result log filled by collect().
  logic [1:0]  resCh [16];
  logic [15:0] resRaw [16];
  logic [11:0] resVolt [16];
  int          resLat [16];
  int          resCnt;
  int          enCyc [4];

  task automatic kick(input logic [3:0] m);
    chanMask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int budget, input int pokeAt, input logic [3:0] pokeMask,
                         output bit timedOut);
    resCnt = 0;
    for (int c = 0; c < 4; c++) enCyc[c] = 0;
    timedOut = 1;
    for (int i = 0; i < budget; i++) begin
      if (i == pokeAt) begin chanMask = pokeMask; start = 1'b1; end
      else start = 1'b0;
      if (adcEnable) enCyc[adcChannel]++;
      if (resultValid && resCnt < 16) begin
        resCh[resCnt] = resultChannel;
        resRaw[resCnt] = resultRaw;
        resVolt[resCnt] = resultVoltage;
        resLat[resCnt] = cyc - readyCyc;
        resCnt++;
      end
      if (!busy) begin timedOut = 0; break; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; chanMask = '0;
    repeat (3) @(negedge clk);
    vectors++; if (adcEnable !== 1'b0) begin miscompares++; $display("FAIL rst_adcEnable got %b want 0", adcEnable); end
    vectors++; if (adcChannel !== 2'd0) begin miscompares++; $display("FAIL rst_adcChannel got %0d want 0", adcChannel); end
    vectors++; if (resultValid !== 1'b0) begin miscompares++; $display("FAIL rst_resultValid got %b want 0", resultValid); end
    vectors++; if (resultChannel !== 2'd0) begin miscompares++; $display("FAIL rst_resultChannel got %0d want 0", resultChannel); end
    vectors++; if (resultRaw !== 16'h0000) begin miscompares++; $display("FAIL rst_resultRaw got %h want 0000", resultRaw); end
    vectors++; if (resultVoltage !== 12'd0) begin miscompares++; $display("FAIL rst_resultVoltage got %0d want 0", resultVoltage); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (timeoutErr !== 1'b0) begin miscompares++; $display("FAIL rst_timeoutErr got %b want 0", timeoutErr); end
    vectors++; if (scanCount !== 8'd0) begin miscompares++; $display("FAIL rst_scanCount got %0d want 0", scanCount); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_scan;
    bit to;
    rawTab[0] = 16'h1F40; rawTab[2] = 16'h0800;
    kick(4'b0101);
    collect(300, -1, 4'b0000, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL single_timeout got busy still high want idle"); end
    vectors++; if (resCnt !== 2) begin miscompares++; $display("FAIL single_count got %0d want 2", resCnt); end
    vectors++; if (resCh[0] !== 2'd0) begin miscompares++; $display("FAIL single_ch0 got %0d want 0", resCh[0]); end
    vectors++; if (resRaw[0] !== 16'h1F40) begin miscompares++; $display("FAIL single_raw0 got %h want 1f40", resRaw[0]); end
    vectors++; if (resVolt[0] !== 12'd1000) begin miscompares++; $display("FAIL single_volt0 got %0d want 1000", resVolt[0]); end
    vectors++; if (resLat[0] !== 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", resLat[0]); end
    vectors++; if (resCh[1] !== 2'd2) begin miscompares++; $display("FAIL single_ch1 got %0d want 2", resCh[1]); end
    vectors++; if (resVolt[1] !== 12'd256) begin miscompares++; $display("FAIL single_volt1 got %0d want 256", resVolt[1]); end
    vectors++; if (scanCount !== 8'd1) begin miscompares++; $display("FAIL single_scanCount got %0d want 1", scanCount); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b want 0", busy); end
    vectors++; if (adcEnable !== 1'b0) begin miscompares++; $display("FAIL single_enable got %b want 0", adcEnable); end
  endtask

  task automatic test_negative_clamp;
    bit to;
    rawTab[1] = 16'h8123;
    kick(4'b0010);
    collect(300, -1, 4'b0000, to);
    vectors++; if (resCnt !== 1) begin miscompares++; $display("FAIL neg_count got %0d want 1", resCnt); end
    vectors++; if (resCh[0] !== 2'd1) begin miscompares++; $display("FAIL neg_ch got %0d want 1", resCh[0]); end
    vectors++; if (resRaw[0] !== 16'h8123) begin miscompares++; $display("FAIL neg_raw got %h want 8123", resRaw[0]); end
    vectors++; if (resVolt[0] !== 12'd0) begin miscompares++; $display("FAIL neg_volt got %0d want 0", resVolt[0]); end
    vectors++; if (scanCount !== 8'd2) begin miscompares++; $display("FAIL neg_scanCount got %0d want 2", scanCount); end
  endtask

  task automatic test_edge_cases;
    bit to;
    chanMask = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zeromask_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    vectors++; if (scanCount !== 8'd2) begin miscompares++; $display("FAIL zeromask_scanCount got %0d want 2", scanCount); end
    vectors++; if (adcEnable !== 1'b0) begin miscompares++; $display("FAIL zeromask_enable got %b want 0", adcEnable); end
    rawTab[0] = 16'h0010; rawTab[2] = 16'h0020; rawTab[3] = 16'h7FF8;
    kick(4'b0101);
    collect(300, 3, 4'b1000, to);
    vectors++; if (resCnt !== 2) begin miscompares++; $display("FAIL oldmask_count got %0d want 2", resCnt); end
    vectors++; if (resCh[0] !== 2'd0) begin miscompares++; $display("FAIL oldmask_ch0 got %0d want 0", resCh[0]); end
    vectors++; if (resCh[1] !== 2'd2) begin miscompares++; $display("FAIL oldmask_ch1 got %0d want 2", resCh[1]); end
    vectors++; if (resVolt[1] !== 12'd4) begin miscompares++; $display("FAIL oldmask_volt1 got %0d want 4", resVolt[1]); end
    vectors++; if (scanCount !== 8'd3) begin miscompares++; $display("FAIL oldmask_scanCount got %0d want 3", scanCount); end
    repeat (20) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL noqueue_busy got %b want 0", busy); end
    vectors++; if (scanCount !== 8'd3) begin miscompares++; $display("FAIL noqueue_scanCount got %0d want 3", scanCount); end
    kick(4'b1000);
    collect(300, -1, 4'b0000, to);
    vectors++; if (resCnt !== 1) begin miscompares++; $display("FAIL newmask_count got %0d want 1", resCnt); end
    vectors++; if (resCh[0] !== 2'd3) begin miscompares++; $display("FAIL newmask_ch got %0d want 3", resCh[0]); end
    vectors++; if (resVolt[0] !== 12'd4095) begin miscompares++; $display("FAIL newmask_volt got %0d want 4095", resVolt[0]); end
    vectors++; if (scanCount !== 8'd4) begin miscompares++; $display("FAIL newmask_scanCount got %0d want 4", scanCount); end
  endtask

  task automatic test_timeout;
    bit to;
    vectors++; if (timeoutErr !== 1'b0) begin miscompares++; $display("FAIL to_pre_err got %b want 0", timeoutErr); end
    stuck[0] = 1; rawTab[1] = 16'h1234;
    kick(4'b0011);
    collect(400, -1, 4'b0000, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL to_scan_hang got busy still high want idle"); end
    vectors++; if (enCyc[0] !== 50) begin miscompares++; $display("FAIL to_enable_cycles got %0d want 50", enCyc[0]); end
    vectors++; if (resCnt !== 1) begin miscompares++; $display("FAIL to_count got %0d want 1", resCnt); end
    vectors++; if (resCh[0] !== 2'd1) begin miscompares++; $display("FAIL to_ch got %0d want 1", resCh[0]); end
    vectors++; if (resRaw[0] !== 16'h1234) begin miscompares++; $display("FAIL to_raw got %h want 1234", resRaw[0]); end
    vectors++; if (resVolt[0] !== 12'd582) begin miscompares++; $display("FAIL to_volt got %0d want 582", resVolt[0]); end
    vectors++; if (timeoutErr !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", timeoutErr); end
    vectors++; if (scanCount !== 8'd5) begin miscompares++; $display("FAIL to_scanCount got %0d want 5", scanCount); end
    stuck[0] = 0; rawTab[0] = 16'h0008;
    kick(4'b0001);
    collect(300, -1, 4'b0000, to);
    vectors++; if (resCnt !== 1 || resVolt[0] !== 12'd1) begin miscompares++; $display("FAIL to_recover got %0d results volt %0d want 1 result volt 1", resCnt, resVolt[0]); end
    vectors++; if (timeoutErr !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b want 1", timeoutErr); end
  endtask

  task automatic test_reset_midconv;
    bit seen;
    int rv;
    rawTab[0] = 16'h0100;
    kick(4'b0001);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (adcEnable && !adcDataReady) begin seen = 1; break; end
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL midconv_reach got %b want 1", seen); end
    @(negedge clk);
    vectors++; if (adcEnable !== 1'b1) begin miscompares++; $display("FAIL midconv_enable got %b want 1", adcEnable); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (adcEnable !== 1'b0) begin miscompares++; $display("FAIL midrst_enable got %b want 0", adcEnable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++; if (timeoutErr !== 1'b0) begin miscompares++; $display("FAIL midrst_err got %b want 0", timeoutErr); end
    vectors++; if (scanCount !== 8'd0) begin miscompares++; $display("FAIL midrst_scanCount got %0d want 0", scanCount); end
    vectors++; if (resultRaw !== 16'h0000 || resultVoltage !== 12'd0) begin miscompares++; $display("FAIL midrst_result got %h/%0d want 0000/0", resultRaw, resultVoltage); end
    reset = 1'b0;
    rv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resultValid) rv++;
    end
    vectors++; if (rv !== 0) begin miscompares++; $display("FAIL midrst_noresult got %0d pulses want 0", rv); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle got %b want 0", busy); end
  endtask

  task automatic test_continuous;
    logic [11:0] expV [4];
    logic [7:0]  prevSc;
    bit          prevEn, wrap, fin;
    int          idx, lastCh3;
    expV[0] = 12'd128; expV[1] = 12'd256; expV[2] = 12'd384; expV[3] = 12'd512;
    rawTab[0] = 16'h0400; rawTab[1] = 16'h0800; rawTab[2] = 16'h0C00; rawTab[3] = 16'h1000;
    chanMask = 4'b1111; continuous = 1'b1;
    prevSc = scanCount; prevEn = 0; wrap = 0; fin = 0; idx = 0; lastCh3 = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (resultValid) begin
        vectors++; if (resultChannel !== 2'(idx % 4)) begin miscompares++; $display("FAIL cont_order[%0d] got %0d want %0d", idx, resultChannel, idx % 4); end
        vectors++; if (resultVoltage !== expV[idx % 4]) begin miscompares++; $display("FAIL cont_volt[%0d] got %0d want %0d", idx, resultVoltage, expV[idx % 4]); end
        if (resultChannel == 2'd3) lastCh3 = cyc;
        idx++;
      end
      if (adcEnable && !prevEn && lastCh3 >= 0) begin
        vectors++; if (cyc - lastCh3 - 1 < 10) begin miscompares++; $display("FAIL cont_gap got %0d idle cycles want >=10", cyc - lastCh3 - 1); end
        lastCh3 = -1;
      end
      prevEn = adcEnable;
      if (scanCount != prevSc) begin
        vectors++; if (scanCount !== 8'(prevSc + 8'd1)) begin miscompares++; $display("FAIL cont_count got %0d want %0d", scanCount, 8'(prevSc + 8'd1)); end
        if (prevSc == 8'd255 && scanCount == 8'd0) begin wrap = 1; continuous = 1'b0; end
        prevSc = scanCount;
      end
      if (wrap && !busy) begin fin = 1; break; end
    end
    vectors++; if (fin !== 1'b1) begin miscompares++; $display("FAIL cont_finish got %b want 1", fin); end
    vectors++; if (idx !== 1024) begin miscompares++; $display("FAIL cont_results got %0d want 1024", idx); end
    vectors++; if (scanCount !== 8'd0) begin miscompares++; $display("FAIL cont_wrap got %0d want 0", scanCount); end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin rawTab[c] = '0; stuck[c] = 0; end
    reset = 1'b1; start = 1'b0; continuous = 1'b0; chanMask = '0;
    @(negedge clk);
    test_reset;
    test_single_scan;
    test_negative_clamp;
    test_edge_cases;
    test_timeout;
    test_reset_midconv;
    test_continuous;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
